// File: rtl/sram_req_arbiter_if.sv
// Request/response bundle shared by both requesters and the memory port.
// A master issues requests (req/wr/size/addr/wdata) and receives the
// handshakes and read data; a slave accepts requests and answers them.
interface sram_req_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              wr;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              addr_ok;
   logic              data_ok;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, wr, size, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between the fetch and load/store
// requesters. One transaction in flight at a time: accept (IDLE), replay on
// the memory port (REQ), wait for and route the response (RESP). Data
// requests win arbitration, except that after MAX_DATA_RUN consecutive data
// grants taken while fetch was waiting, fetch is granted once.
module sram_req_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic                clk,
   input  logic                reset,
   sram_req_arbiter_if.slave   inst,
   sram_req_arbiter_if.slave   data,
   sram_req_arbiter_if.master  mem
);
   localparam int CNT_W = $clog2(MAX_DATA_RUN + 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t            state;
   state_t            state_next;
   logic              owner_data;
   logic [CNT_W-1:0]  run_cnt;
   logic              lat_wr;
   logic [1:0]        lat_size;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic              starve;
   logic              grant_data;
   logic              grant_inst;
   logic              resp_done;

   // Reset is folded into the grant so no handshake leaks out while reset is held.
   assign starve     = inst.req && (run_cnt == CNT_W'(MAX_DATA_RUN));
   assign grant_data = (state == IDLE) && !reset && data.req && !starve;
   assign grant_inst = (state == IDLE) && !reset && inst.req && !grant_data;
   assign resp_done  = (state == RESP) && mem.data_ok;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Capture the granted request and its owner; held until the next grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_data <= 1'b0;
         lat_wr     <= 1'b0;
         lat_size   <= 2'd0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
      end else if (grant_data) begin
         owner_data <= 1'b1;
         lat_wr     <= data.wr;
         lat_size   <= data.size;
         lat_addr   <= data.addr;
         lat_wdata  <= data.wdata;
      end else if (grant_inst) begin
         owner_data <= 1'b0;
         lat_wr     <= inst.wr;
         lat_size   <= inst.size;
         lat_addr   <= inst.addr;
         lat_wdata  <= inst.wdata;
      end
   end

   // Count data grants taken while fetch waits; any other grant clears the run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_cnt <= '0;
      end else if (grant_data && inst.req) begin
         if (run_cnt != CNT_W'(MAX_DATA_RUN)) run_cnt <= run_cnt + CNT_W'(1);
      end else if (grant_data || grant_inst) begin
         run_cnt <= '0;
      end
   end

   // Next-state logic: memory handshakes only matter in their own state.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (grant_data || grant_inst) state_next = REQ;
         REQ:  if (mem.addr_ok)              state_next = RESP;
         RESP: if (mem.data_ok)              state_next = IDLE;
         default:                            state_next = IDLE;
      endcase
   end

   // Outputs: handshakes, memory replay and response routing to the owner.
   always_comb begin
      inst.addr_ok = grant_inst;
      data.addr_ok = grant_data;
      mem.req      = (state == REQ);
      mem.wr       = lat_wr;
      mem.size     = lat_size;
      mem.addr     = lat_addr;
      mem.wdata    = lat_wdata;
      inst.data_ok = resp_done && !owner_data;
      data.data_ok = resp_done && owner_data;
      inst.rdata   = '0;
      data.rdata   = '0;
      if (inst.data_ok) inst.rdata = mem.rdata;
      if (data.data_ok) data.rdata = mem.rdata;
   end
endmodule
